// File: rtl/edge_pulse_generator.sv
// edge_pulse_generator: turns request pulses into width-controlled edges with a minimum deasserted gap.
// Define EDGE_PULSE_GEN_PENDING_EN to queue requests that arrive while busy instead of dropping them.
module edge_pulse_generator #(
  parameter int EDGE_TYPE = 0,
  parameter int WIDTH_W   = 8,
  parameter int MIN_GAP   = 2,
  parameter int PEND_W    = 4
) (
  input  logic               clk,
  input  logic               reset_qual_n,
  input  logic               pulse_in,
  input  logic [WIDTH_W-1:0] width_cfg,
  output logic               signal_out,
  output logic               busy,
  output logic               done,
  output logic               req_dropped,
  output logic [PEND_W-1:0]  pend_cnt
);
  localparam int CW = (WIDTH_W > 8) ? WIDTH_W : 8;
  localparam logic SIG_ON = (EDGE_TYPE != 0);
  localparam logic SIG_OFF = !SIG_ON;
  localparam logic [CW-1:0] GAP_LAST = CW'(MIN_GAP - 1);
  generate
    if (MIN_GAP < 1 || MIN_GAP > 255) begin : g_bad_gap
      $error("MIN_GAP must be in 1..255");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, GAP = 2'd2} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sig, r_busy, r_done, r_drop;
  logic [CW-1:0] w_load;
  logic          w_gap_end, w_busy_st, w_has_pend, w_drop;
  assign w_load    = (width_cfg == '0) ? '0 : CW'(width_cfg) - CW'(1);
  assign w_gap_end = (r_state == GAP) && (r_cnt == '0);
  assign w_busy_st = (r_state == ASSERT) || (r_state == GAP);
`ifdef EDGE_PULSE_GEN_PENDING_EN
  logic [PEND_W-1:0] r_pend;
  logic              w_pend_max, w_queue, w_inc, w_dec;
  assign w_has_pend = (r_pend != '0);
  assign w_pend_max = &r_pend;
  // A replay starts either at GAP exit or from IDLE after a GAP-exit request was parked
  assign w_dec   = (w_gap_end || r_state == IDLE) && w_has_pend;
  assign w_queue = pulse_in && (w_busy_st || (r_state == IDLE && w_has_pend));
  assign w_inc   = w_queue && (!w_pend_max || w_dec);
  assign w_drop  = w_queue && w_pend_max && !w_dec;
  assign pend_cnt = r_pend;
  always_ff @(posedge clk or negedge reset_qual_n)
    if (!reset_qual_n) r_pend <= '0;
    else if (w_inc != w_dec) r_pend <= w_inc ? r_pend + 1'b1 : r_pend - 1'b1;
`else
  assign w_has_pend = 1'b0;
  assign w_drop     = pulse_in && w_busy_st;
  assign pend_cnt   = '0;
`endif
  always_ff @(posedge clk or negedge reset_qual_n)
    if (!reset_qual_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sig   <= SIG_OFF;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_drop;
      r_done <= 1'b0;
      case (r_state)
        IDLE:
          if (pulse_in || w_has_pend) begin
            r_state <= ASSERT;
            r_cnt   <= w_load;
            r_sig   <= SIG_ON;
            r_busy  <= 1'b1;
          end
        ASSERT:
          if (r_cnt == '0) begin
            r_state <= GAP;
            r_cnt   <= GAP_LAST;
            r_sig   <= SIG_OFF;
            r_done  <= (GAP_LAST == '0);
          end else r_cnt <= r_cnt - 1'b1;
        GAP:
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - 1'b1;
            r_done <= (r_cnt == CW'(1));
          end else if (w_has_pend) begin
            r_state <= ASSERT;
            r_cnt   <= w_load;
            r_sig   <= SIG_ON;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_sig   <= SIG_OFF;
          r_busy  <= 1'b0;
        end
      endcase
    end
  assign signal_out  = r_sig;
  assign busy        = r_busy;
  assign done        = r_done;
  assign req_dropped = r_drop;
endmodule

// File: tb/tb_edge_pulse_generator.sv
// tb_edge_pulse_generator: directed checks of edge_pulse_generator for both edge polarities.
module tb_edge_pulse_generator;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       p0 = 1'b0, p1 = 1'b0;
  logic [7:0] w0 = 8'd0, w1 = 8'd0;
  logic       s0, b0, d0, r0, s1, b1, d1, r1;
  logic [3:0] pc0;
  logic [1:0] pc1;
  int n_checks = 0, n_fail = 0;
  int ons, dones, drops, last_done;
  always #5 clk = ~clk;
  edge_pulse_generator #(.EDGE_TYPE(0)) u_dut0 (
    .clk(clk), .reset_qual_n(rst_n), .pulse_in(p0), .width_cfg(w0),
    .signal_out(s0), .busy(b0), .done(d0), .req_dropped(r0), .pend_cnt(pc0));
  edge_pulse_generator #(.EDGE_TYPE(1), .PEND_W(2)) u_dut1 (
    .clk(clk), .reset_qual_n(rst_n), .pulse_in(p1), .width_cfg(w1),
    .signal_out(s1), .busy(b1), .done(d1), .req_dropped(r1), .pend_cnt(pc1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Counts pulse starts (edges into the asserted level), done and drop pulses over n cycles
  task automatic run(input int sel, input int n, output int o_ons, output int o_dones,
                     output int o_drops, output int o_last);
    logic prev, cur;
    prev = sel ? s1 : s0;
    o_ons = 0; o_dones = 0; o_drops = 0; o_last = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      cur = sel ? s1 : s0;
      if (sel ? (!prev && cur) : (prev && !cur)) o_ons++;
      prev = cur;
      if (sel ? d1 : d0) begin o_dones++; o_last = i; end
      if (sel ? r1 : r0) o_drops++;
    end
  endtask
  logic [2:0] exp1 [7] = '{3'b010, 3'b010, 3'b010, 3'b110, 3'b111, 3'b100, 3'b100};
  logic [2:0] exp2 [5] = '{3'b110, 3'b010, 3'b011, 3'b000, 3'b000};
  logic [2:0] exp6 [5] = '{3'b010, 3'b010, 3'b110, 3'b111, 3'b100};
  initial begin
    repeat (3) @(negedge clk);
    check("rst_sig0", 32'(s0), 32'd1);
    check("rst_busy0", 32'(b0), 32'd0);
    check("rst_done0", 32'(d0), 32'd0);
    check("rst_drop0", 32'(r0), 32'd0);
    check("rst_pend0", 32'(pc0), 32'd0);
    check("rst_sig1", 32'(s1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // Falling-edge signalling, width 3
    p0 = 1'b1; w0 = 8'd3;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      p0 = 1'b0;
      check($sformatf("t1_obs%0d", k + 1), 32'({s0, b0, d0}), 32'(exp1[k]));
    end
    // Rising-edge signalling, width 0 treated as 1
    p1 = 1'b1; w1 = 8'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      p1 = 1'b0;
      check($sformatf("t2_obs%0d", k + 1), 32'({s1, b1, d1}), 32'(exp2[k]));
    end
`ifndef EDGE_PULSE_GEN_PENDING_EN
    // Request during ASSERT is dropped
    p0 = 1'b1; w0 = 8'd3;
    @(negedge clk);
    @(negedge clk);
    check("t5_drop", 32'(r0), 32'd1);
    check("t5_pend", 32'(pc0), 32'd0);
    p0 = 1'b0;
    @(negedge clk);
    check("t5_drop_clr", 32'(r0), 32'd0);
    run(0, 10, ons, dones, drops, last_done);
    check("t5_no_extra", 32'(ons), 32'd0);
    check("t5_dones", 32'(dones), 32'd1);
    // Request on the GAP-exit cycle is dropped; an IDLE request right after is accepted
    p0 = 1'b1; w0 = 8'd1;
    @(negedge clk);
    p0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("tg_done", 32'(d0), 32'd1);
    p0 = 1'b1;
    @(negedge clk);
    check("tg_exit", 32'({s0, b0, r0}), 32'b101);
    @(negedge clk);
    p0 = 1'b0;
    check("tg_accept", 32'({s0, b0, r0}), 32'b010);
    run(0, 6, ons, dones, drops, last_done);
    check("tg_dones", 32'(dones), 32'd1);
`else
    // Three requests queued behind a width-4 pulse
    p0 = 1'b1; w0 = 8'd4;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("t3_pend%0d", k), 32'(pc0), 32'(k));
    end
    p0 = 1'b0;
    run(0, 30, ons, dones, drops, last_done);
    check("t3_pulses", 32'(ons), 32'd3);
    check("t3_dones", 32'(dones), 32'd4);
    check("t3_last_done", 32'(last_done), 32'd20);
    check("t3_pend_end", 32'(pc0), 32'd0);
    // Saturation with a 2-bit pending counter
    p1 = 1'b1; w1 = 8'd8;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 2) check($sformatf("t4_pend%0d", k), 32'(pc1), 32'((k - 1 > 3) ? 3 : k - 1));
      check($sformatf("t4_drop%0d", k), 32'(r1), 32'(k >= 5));
    end
    p1 = 1'b0;
    run(1, 40, ons, dones, drops, last_done);
    check("t4_pulses", 32'(ons), 32'd3);
    check("t4_drops", 32'(drops), 32'd0);
    check("t4_pend_end", 32'(pc1), 32'd0);
`endif
    // Asynchronous reset mid-ASSERT, then a full pulse
    p0 = 1'b1; w0 = 8'd5;
    @(negedge clk);
    p0 = 1'b0;
    @(negedge clk);
    check("t6_pre", 32'(s0), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_sig", 32'(s0), 32'd1);
    check("t6_async_busy", 32'(b0), 32'd0);
    run(0, 3, ons, dones, drops, last_done);
    check("t6_no_done", 32'(dones), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    p0 = 1'b1; w0 = 8'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      p0 = 1'b0;
      check($sformatf("t6_obs%0d", k + 1), 32'({s0, b0, d0}), 32'(exp6[k]));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_pulse_generator.md
Name: edge_pulse_generator

Overview:
- Transmit-side counterpart of the edge detector: turns single-cycle request pulses into clean, width-controlled edges on a level signal.
- A downstream edge detector of matching EDGE_TYPE sees exactly one edge per accepted request.
- Enforces a minimum deasserted gap between pulses so the receiver always re-arms.
- Sits between control logic (register writes, sequencers) and outgoing strobe/handshake lines.

Parameters:
- EDGE_TYPE, 0: 0 = falling-edge signalling (idle high, asserted low); 1 = rising-edge signalling (idle low, asserted high).
- WIDTH_W, 8: width of width_cfg and of the internal assert counter.
- MIN_GAP, 2: deasserted cycles after each pulse. Legal range 1..255; synthesis error if 0.
- PEND_W, 4: width of the pending-request counter. Maximum pending = 2^PEND_W-1.

Ports:
- clk, input, 1: clock.
- reset_qual_n, input, 1: asynchronous, active-low reset.
- pulse_in, input, 1: request. Each cycle it is high counts as one request.
- width_cfg, input, WIDTH_W: assert duration in cycles. Sampled when a pulse starts; 0 is treated as 1.
- signal_out, output, 1: generated edge signal, registered.
- busy, output, 1: high while in ASSERT or GAP.
- done, output, 1: one-cycle pulse when a pulse's gap completes.
- req_dropped, output, 1: one-cycle pulse when a request is lost.
- pend_cnt, output, PEND_W: requests queued behind the active pulse.

Behaviour:
- SIG_ON = EDGE_TYPE ? 1 : 0; SIG_OFF = ~SIG_ON.
- Reset (async, immediate, also mid-pulse):
  - state = IDLE, signal_out = SIG_OFF, busy = 0, done = 0, req_dropped = 0, pend_cnt = 0.
  - Counters cleared. No done is issued for an aborted pulse.
- FSM states IDLE, ASSERT, GAP:
  - IDLE: pulse_in = 1 at edge N → latch w = max(width_cfg, 1), go to ASSERT. signal_out = SIG_ON from cycle N+1.
  - ASSERT: signal_out = SIG_ON for exactly w cycles, then GAP.
  - GAP: signal_out = SIG_OFF for exactly MIN_GAP cycles. done = 1 on the last GAP cycle.
    - At GAP exit with pend_cnt > 0: go directly to ASSERT, decrement pend_cnt, re-sample width_cfg.
    - Otherwise go to IDLE.
  - Illegal state encoding → IDLE next cycle, signal_out = SIG_OFF.
- signal_out, busy, done and req_dropped are all registered. No combinational path from pulse_in.
- Request latency is 1 cycle from an IDLE accept.
- Back-to-back throughput: one pulse every w + MIN_GAP cycles.
- pulse_in while busy is handled per Optional Feature.
- Simultaneous pulse_in on the GAP-exit cycle with pend_cnt > 0: increment and decrement cancel, so pend_cnt is unchanged.
- Simultaneous pulse_in on the GAP-exit cycle with pend_cnt = 0: the request is queued (pend_cnt = 1) and served after the following IDLE cycle. Never lost.
- pulse_in held high for k cycles counts as k requests.
- width_cfg changes during ASSERT have no effect on the current pulse.

Optional Feature:
- Macro: EDGE_PULSE_GEN_PENDING_EN.
- Defined:
  - pulse_in while busy increments pend_cnt (saturating at 2^PEND_W-1).
  - Requests queued this way are replayed in order.
  - A request arriving while pend_cnt is at max pulses req_dropped, and pend_cnt stays at max.
- Undefined:
  - Any pulse_in while busy pulses req_dropped and is discarded.
  - pend_cnt is tied to 0, the counter is not built, and the GAP-exit queue case does not apply (that request is dropped).

Test Plan:
1. EDGE_TYPE=0, reset then release:
   - signal_out = 1, busy = 0 after reset.
   - pulse_in high 1 cycle, width_cfg = 3: signal_out = 0 for cycles N+1..N+3, then 1 for 2 cycles.
   - done high on cycle N+5; busy low on cycle N+6.
2. width_cfg = 0, EDGE_TYPE=1: single-cycle high on signal_out, then 2 low cycles; done fires once.
3. With macro, width_cfg = 4, 3 requests during the first pulse:
   - pend_cnt rises 1→2→3.
   - Three further pulses follow, each separated by exactly MIN_GAP off cycles.
   - Four done pulses in total; pend_cnt ends at 0.
4. With macro, PEND_W = 2, 5 requests while busy:
   - pend_cnt saturates at 3.
   - req_dropped pulses on the 4th and 5th requests; 4 pulses in total.
5. Without macro, pulse_in during ASSERT: req_dropped = 1 for one cycle, no extra pulse, pend_cnt stays 0.
6. Assert reset_qual_n low mid-ASSERT:
   - signal_out returns to SIG_OFF asynchronously; no done.
   - After release, a new request produces a full-width pulse.
